// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between a core port and a burst engine
// Core requests are single-cycle; the burst engine walks base..base+len-1 and alternates with the core on contention.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  input  logic          b_start,
  input  logic          b_we,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] b_len,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_busy,
  output logic          b_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic WIN_A = 1'b0;
  localparam logic WIN_B = 1'b1;
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic          we_q, we_d;
  logic          last_q, last_d;

  logic eng_req;
  logic a_win;
  logic b_win;

  assign eng_req = (state_q == S_BURST);

  // Reset masks every grant so nothing reaches memory while RST is high.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (!RST) begin
      if (a_req && eng_req) begin
        a_win = (last_q == WIN_B);
        b_win = (last_q == WIN_A);
      end else begin
        a_win = a_req;
        b_win = eng_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (a_win) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_we    = a_we;
    end else if (b_win) begin
      mem_addr  = base_q + cnt_q;
      mem_wdata = b_wdata;
      mem_we    = we_q;
    end
  end

  assign a_gnt   = a_win;
  assign b_ack   = b_win;
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;
  assign b_busy  = (state_q != S_IDLE);
  assign b_done  = (state_q == S_DONE) && !RST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    we_d    = we_q;
    last_d  = last_q;
    if (a_req && eng_req) begin
      last_d = a_win ? WIN_A : WIN_B;
    end
    case (state_q)
      S_IDLE: begin
        if (b_start) begin
          we_d    = b_we;
          base_d  = b_base;
          len_d   = b_len;
          cnt_d   = '0;
          state_d = (b_len != '0) ? S_BURST : S_DONE;
        end
      end
      S_BURST: begin
        if (b_win) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == len_q - ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      last_q  <= WIN_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      we_q    <= we_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Vector table, hand-written corner sequences, then random traffic against a queue-based reference model.
module tb_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       a_req, a_we, a_gnt;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_start, b_we, b_ack, b_busy, b_done;
  logic [7:0] b_base, b_len, b_wdata, b_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  logic [7:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata),
    .b_start(b_start), .b_we(b_we), .b_base(b_base), .b_len(b_len), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_busy(b_busy), .b_done(b_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic rst, a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic b_start, b_we;
    logic [7:0] b_base, b_len, b_wdata;
    logic e_gnt, e_ack, e_we;
    logic [7:0] e_addr;
    logic e_busy, e_done, chk_rd;
    logic [7:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ar, input logic aw, input logic [7:0] aa,
                              input logic [7:0] ad, input logic bs, input logic bw, input logic [7:0] bb,
                              input logic [7:0] bl, input logic [7:0] bd, input logic eg, input logic ea,
                              input logic ew, input logic [7:0] eaddr, input logic ebusy, input logic edone,
                              input logic crd, input logic [7:0] erd);
    vec_t v;
    v.rst = rst; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_start = bs; v.b_we = bw; v.b_base = bb; v.b_len = bl; v.b_wdata = bd;
    v.e_gnt = eg; v.e_ack = ea; v.e_we = ew; v.e_addr = eaddr;
    v.e_busy = ebusy; v.e_done = edone; v.chk_rd = crd; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    RST = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_start = 1'b0; b_we = 1'b0; b_base = '0; b_len = '0; b_wdata = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic core(input logic we, input logic [7:0] addr, input logic [7:0] data);
    quiet();
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic do_reset();
    quiet();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  vec_t vec [21];

  // Reference model state: remaining burst addresses, pending done pulse, contest priority.
  logic [7:0] bq [$];
  bit         done_flag;
  bit         bwe;
  bit         a_turn;
  logic [7:0] ref_mem [256];
  bit         known [256];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    vec[0]  = mk(1,1,1,8'h00,8'd33, 1,1,8'h10,8'd3,8'd0, 0,0,0,8'h00,0,0, 0,8'd0);
    vec[1]  = mk(0,1,1,8'h00,8'd33, 0,0,8'h00,8'd0,8'd0, 1,0,1,8'h00,0,0, 0,8'd0);
    vec[2]  = mk(0,1,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd0, 1,0,0,8'h00,0,0, 1,8'd33);
    vec[3]  = mk(0,0,0,8'h00,8'd0,  1,1,8'h10,8'd3,8'd1, 0,0,0,8'h00,0,0, 0,8'd0);
    vec[4]  = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd1, 0,1,1,8'h10,1,0, 0,8'd0);
    vec[5]  = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd2, 0,1,1,8'h11,1,0, 0,8'd0);
    vec[6]  = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd3, 0,1,1,8'h12,1,0, 0,8'd0);
    vec[7]  = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd0, 0,0,0,8'h00,1,1, 0,8'd0);
    vec[8]  = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd0, 0,0,0,8'h00,0,0, 0,8'd0);
    vec[9]  = mk(0,1,0,8'h11,8'd0,  0,0,8'h00,8'd0,8'd0, 1,0,0,8'h11,0,0, 1,8'd2);
    vec[10] = mk(0,1,0,8'h12,8'd0,  0,0,8'h00,8'd0,8'd0, 1,0,0,8'h12,0,0, 1,8'd3);
    vec[11] = mk(0,1,1,8'h40,8'h55, 1,1,8'hFE,8'd3,8'd7, 1,0,1,8'h40,0,0, 0,8'd0);
    vec[12] = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd7, 0,1,1,8'hFE,1,0, 0,8'd0);
    vec[13] = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd8, 0,1,1,8'hFF,1,0, 0,8'd0);
    vec[14] = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd9, 0,1,1,8'h00,1,0, 0,8'd0);
    vec[15] = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd0, 0,0,0,8'h00,1,1, 0,8'd0);
    vec[16] = mk(0,1,0,8'hFF,8'd0,  0,0,8'h00,8'd0,8'd0, 1,0,0,8'hFF,0,0, 1,8'd8);
    vec[17] = mk(0,0,0,8'h00,8'd0,  1,0,8'h20,8'd0,8'd0, 0,0,0,8'h00,0,0, 0,8'd0);
    vec[18] = mk(0,0,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd0, 0,0,0,8'h00,1,1, 0,8'd0);
    vec[19] = mk(0,1,0,8'h00,8'd0,  0,0,8'h00,8'd0,8'd0, 1,0,0,8'h00,0,0, 1,8'd9);
    vec[20] = mk(0,1,0,8'h40,8'd0,  0,0,8'h00,8'd0,8'd0, 1,0,0,8'h40,0,0, 1,8'h55);

    do_reset();

    for (int i = 0; i < 21; i++) begin
      RST = vec[i].rst; a_req = vec[i].a_req; a_we = vec[i].a_we;
      a_addr = vec[i].a_addr; a_wdata = vec[i].a_wdata;
      b_start = vec[i].b_start; b_we = vec[i].b_we; b_base = vec[i].b_base;
      b_len = vec[i].b_len; b_wdata = vec[i].b_wdata;
      #4;
      chk($sformatf("v%0d_a_gnt", i), a_gnt, vec[i].e_gnt);
      chk($sformatf("v%0d_b_ack", i), b_ack, vec[i].e_ack);
      chk($sformatf("v%0d_mem_we", i), mem_we, vec[i].e_we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
      chk($sformatf("v%0d_b_busy", i), b_busy, vec[i].e_busy);
      chk($sformatf("v%0d_b_done", i), b_done, vec[i].e_done);
      if (vec[i].chk_rd) chk($sformatf("v%0d_a_rdata", i), a_rdata, vec[i].e_rd);
      tick();
    end

    // Contention: core held against a 4-word read burst, A wins first.
    do_reset();
    quiet();
    b_start = 1'b1; b_we = 1'b0; b_base = 8'h20; b_len = 8'd4;
    tick();
    begin
      bit seen_done = 0;
      core(1'b0, 8'h05, 8'h00);
      for (int t = 0; t < 20 && !seen_done; t++) begin
        #4;
        if (b_done) begin
          seen_done = 1;
          chk("contend_cycles", t, 8);
        end else begin
          chk($sformatf("contend_t%0d_a_gnt", t), a_gnt, (t % 2) == 0);
          chk($sformatf("contend_t%0d_b_ack", t), b_ack, (t % 2) == 1);
          if (b_ack) chk($sformatf("contend_t%0d_addr", t), mem_addr, 8'h20 + 8'(t / 2));
        end
        chk($sformatf("contend_t%0d_exclusive", t), a_gnt & b_ack, 0);
        tick();
      end
      if (!seen_done) chk("contend_timeout", 0, 1);
    end

    // Reset two words into a five-word write burst.
    core(1'b1, 8'h82, 8'h11); tick();
    core(1'b1, 8'h83, 8'h22); tick();
    core(1'b1, 8'h84, 8'h33); tick();
    quiet();
    b_start = 1'b1; b_we = 1'b1; b_base = 8'h80; b_len = 8'd5;
    tick();
    quiet();
    for (int n = 0; n < 2; n++) begin
      b_wdata = 8'hA0 + 8'(n);
      #4;
      chk($sformatf("rstmid_ack%0d", n), b_ack, 1);
      chk($sformatf("rstmid_addr%0d", n), mem_addr, 8'h80 + 8'(n));
      tick();
    end
    RST = 1'b1; b_wdata = 8'hA2;
    #4;
    chk("rstmid_rst_ack", b_ack, 0);
    chk("rstmid_rst_we", mem_we, 0);
    chk("rstmid_rst_done", b_done, 0);
    tick();
    quiet();
    #4;
    chk("rstmid_after_busy", b_busy, 0);
    chk("rstmid_after_done", b_done, 0);
    chk("rstmid_after_we", mem_we, 0);
    tick();
    #4;
    chk("rstmid_after2_done", b_done, 0);
    tick();
    for (int n = 0; n < 5; n++) begin
      logic [7:0] exp_v [5];
      exp_v[0] = 8'hA0; exp_v[1] = 8'hA1; exp_v[2] = 8'h11; exp_v[3] = 8'h22; exp_v[4] = 8'h33;
      core(1'b0, 8'h80 + 8'(n), 8'h00);
      #4;
      chk($sformatf("rstmid_mem%0d", n), a_rdata, exp_v[n]);
      tick();
    end

    // b_start during BURST is ignored.
    quiet();
    b_start = 1'b1; b_we = 1'b1; b_base = 8'h30; b_len = 8'd3;
    tick();
    for (int n = 0; n < 3; n++) begin
      quiet();
      b_wdata = 8'hC0 + 8'(n);
      if (n == 1) begin
        b_start = 1'b1; b_we = 1'b0; b_base = 8'h90; b_len = 8'd7;
      end
      #4;
      chk($sformatf("ignore_ack%0d", n), b_ack, 1);
      chk($sformatf("ignore_addr%0d", n), mem_addr, 8'h30 + 8'(n));
      chk($sformatf("ignore_we%0d", n), mem_we, 1);
      tick();
    end
    quiet();
    #4;
    chk("ignore_done", b_done, 1);
    chk("ignore_done_ack", b_ack, 0);
    tick();
    #4;
    chk("ignore_idle_busy", b_busy, 0);
    tick();

    // Random traffic against the reference model.
    do_reset();
    bq.delete(); done_flag = 0; bwe = 0; a_turn = 1;
    for (int i = 0; i < 256; i++) known[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit eng, idle, exp_a, exp_b, exp_we, exp_busy, exp_done;
      logic [7:0] exp_addr, exp_wdata;
      RST     = ($urandom_range(0, 59) == 0);
      a_req   = ($urandom_range(0, 2) != 0);
      a_we    = 1'($urandom);
      a_addr  = 8'($urandom_range(0, 31));
      a_wdata = 8'($urandom);
      b_start = ($urandom_range(0, 5) == 0);
      b_we    = 1'($urandom);
      b_base  = ($urandom_range(0, 3) == 0) ? 8'hFC : 8'($urandom_range(0, 15));
      b_len   = 8'($urandom_range(0, 6));
      b_wdata = 8'($urandom);
      #4;
      eng = (bq.size() > 0);
      exp_a = 0; exp_b = 0;
      if (!RST) begin
        if (a_req && eng) begin
          exp_a = a_turn;
          exp_b = !a_turn;
        end else begin
          exp_a = a_req;
          exp_b = eng;
        end
      end
      exp_addr = 8'h00; exp_wdata = 8'h00; exp_we = 0;
      if (exp_a) begin
        exp_addr = a_addr; exp_wdata = a_wdata; exp_we = a_we;
      end else if (exp_b) begin
        exp_addr = bq[0]; exp_wdata = b_wdata; exp_we = bwe;
      end
      exp_busy = eng || done_flag;
      exp_done = done_flag && !RST;
      chk($sformatf("rnd%0d_a_gnt", cyc), a_gnt, exp_a);
      chk($sformatf("rnd%0d_b_ack", cyc), b_ack, exp_b);
      chk($sformatf("rnd%0d_mem_we", cyc), mem_we, exp_we);
      chk($sformatf("rnd%0d_mem_addr", cyc), mem_addr, exp_addr);
      chk($sformatf("rnd%0d_mem_wdata", cyc), mem_wdata, exp_wdata);
      chk($sformatf("rnd%0d_b_busy", cyc), b_busy, exp_busy);
      chk($sformatf("rnd%0d_b_done", cyc), b_done, exp_done);
      if ((exp_a || exp_b) && !exp_we && known[exp_addr]) begin
        if (exp_a) chk($sformatf("rnd%0d_a_rdata", cyc), a_rdata, ref_mem[exp_addr]);
        else       chk($sformatf("rnd%0d_b_rdata", cyc), b_rdata, ref_mem[exp_addr]);
      end
      if (exp_we) begin
        ref_mem[exp_addr] = exp_wdata;
        known[exp_addr] = 1;
      end
      if (RST) begin
        bq.delete(); done_flag = 0; a_turn = 1;
      end else begin
        idle = !eng && !done_flag;
        if (a_req && eng) a_turn = !exp_a;
        done_flag = 0;
        if (exp_b) begin
          void'(bq.pop_front());
          if (bq.size() == 0) done_flag = 1;
        end
        if (idle && b_start) begin
          bwe = b_we;
          for (int k = 0; k < int'(b_len); k++) bq.push_back(b_base + 8'(k));
          if (b_len == 8'd0) done_flag = 1;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
